// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op codes and MEM-stage FSM encoding.
package mem_stage_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_PASS   = 3'd3,
    ST_FLUSH  = 3'd4
  } mem_state_e;

  // Word accesses only: both low address bits must be clear.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: consumes the EX/MEM bundle, performs at most one word access on
// the data-memory req/ack bus, loads MEM/WB and pulses o_flush back to EX.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alu_ready,
  input  logic [XLEN-1:0]       i_result,
  input  logic [XLEN-1:0]       i_store_data,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  o_flush,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [XLEN-1:0]       o_dmem_addr,
  output logic [XLEN-1:0]       o_dmem_wdata,
  input  logic [XLEN-1:0]       i_dmem_rdata,
  input  logic                  i_dmem_ack,
  output logic                  o_wb_valid,
  output logic [XLEN-1:0]       o_wb_data,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic                  o_wb_we,
  input  logic                  i_wb_flush,
  output logic                  o_mem_err
);

  localparam int               CNT_W     = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DMEM_TIMEOUT);

  mem_state_e r_state;
  mem_state_e w_state_next;

  logic                  r_ready_d;
  logic                  w_start;

  // Capture registers for the EX/MEM bundle.
  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_is_load;
  logic                  r_is_store;
  logic [XLEN-1:0]       r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_mem_err;

  // MEM/WB register.
  logic                  r_wb_valid;
  logic [XLEN-1:0]       r_wb_data;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_we;

  logic                  w_mem_op;
  logic                  w_aligned;
  logic                  w_in_access;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_cnt_hit;
  logic                  w_load_wb;

  assign w_start     = i_alu_ready & ~r_ready_d;
  assign w_mem_op    = i_mem_read | i_mem_write;
  assign w_aligned   = is_word_aligned(i_result[1:0]);
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_cnt_hit   = (w_cnt_inc == CNT_LIMIT);
  assign w_load_wb   = (r_state == ST_PASS) & ~r_wb_valid;

  // The edge detector follows i_alu_ready even while reset is asserted, so a ready level
  // that EX keeps high across a reset is not mistaken for a fresh EX/MEM entry.
  always_ff @(posedge clk) begin
    r_ready_d <= i_alu_ready;
  end

  // NOTE: sequential state uses non-blocking assignments and the reset is synchronous,
  // so the reset branch lives inside the clocked block with no reset in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default at the top of the block makes every path assign w_state_next, so no latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_next = ST_LATCH;
      ST_LATCH:  w_state_next = (w_mem_op && w_aligned) ? ST_ACCESS : ST_PASS;
      ST_ACCESS: if (i_dmem_ack || w_cnt_hit) w_state_next = ST_PASS;
      ST_PASS:   if (!r_wb_valid) w_state_next = ST_FLUSH;
      ST_FLUSH:  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_LATCH: begin
          r_addr     <= i_result;
          r_wdata    <= i_store_data;
          r_rd       <= i_rd;
          r_is_load  <= i_mem_read;
          r_is_store <= i_mem_write & ~i_mem_read;
          r_cnt      <= '0;
          if (w_mem_op && !w_aligned) begin
            r_mem_err <= 1'b1;
            r_data    <= '0;
          end else begin
            r_data    <= i_result;
          end
        end
        ST_ACCESS: begin
          // An ack in the limit cycle still completes the access normally.
          if (i_dmem_ack) begin
            if (r_is_load) r_data <= i_dmem_rdata;
          end else if (w_cnt_hit) begin
            r_mem_err <= 1'b1;
            r_data    <= '0;
          end else begin
            r_cnt     <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // A load into MEM/WB takes priority over a same-cycle consume from WB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
      r_wb_we    <= 1'b0;
    end else if (w_load_wb) begin
      r_wb_valid <= 1'b1;
      r_wb_data  <= r_data;
      r_wb_rd    <= r_rd;
      r_wb_we    <= ~r_is_store;
    end else if (i_wb_flush) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign o_flush      = (r_state == ST_FLUSH);
  assign o_dmem_req   = w_in_access;
  assign o_dmem_we    = w_in_access & r_is_store;
  assign o_dmem_addr  = w_in_access ? r_addr  : '0;
  assign o_dmem_wdata = w_in_access ? r_wdata : '0;
  assign o_wb_valid   = r_wb_valid;
  assign o_wb_data    = r_wb_data;
  assign o_wb_rd      = r_wb_rd;
  assign o_wb_we      = r_wb_we;
  assign o_mem_err    = r_mem_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: transaction-level model plus per-cycle output compare.
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  typedef struct {
    logic [31:0] result;
    logic [31:0] sdata;
    logic        rd_en;
    logic        wr_en;
    logic [4:0]  rd;
    int          ack_after;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    bit          bus;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          dmem_we;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    bit          wb_we;
    bit          err;
    int          req_cycles;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_alu_ready;
  logic [31:0] i_result;
  logic [31:0] i_store_data;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [4:0]  i_rd;
  logic        o_flush;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [31:0] i_dmem_rdata;
  logic        i_dmem_ack;
  logic        o_wb_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_wb_we;
  logic        i_wb_flush;
  logic        o_mem_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cur_active = 0;
  bit   model_err  = 0;
  exp_t cur_exp;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DMEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_alu_ready  (i_alu_ready),
    .i_result     (i_result),
    .i_store_data (i_store_data),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_rd         (i_rd),
    .o_flush      (o_flush),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .i_dmem_rdata (i_dmem_rdata),
    .i_dmem_ack   (i_dmem_ack),
    .o_wb_valid   (o_wb_valid),
    .o_wb_data    (o_wb_data),
    .o_wb_rd      (o_wb_rd),
    .o_wb_we      (o_wb_we),
    .i_wb_flush   (i_wb_flush),
    .o_mem_err    (o_mem_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] result, input logic [31:0] sdata,
                              input logic rd_en, input logic wr_en, input logic [4:0] rd,
                              input int ack_after, input logic [31:0] rdata);
    txn_t t;
    t.result = result; t.sdata = sdata; t.rd_en = rd_en; t.wr_en = wr_en;
    t.rd = rd; t.ack_after = ack_after; t.rdata = rdata;
    return t;
  endfunction

  // What one EX/MEM entry must produce, derived from the access rules alone.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    bit memop;
    bit store;
    memop = t.rd_en || t.wr_en;
    store = t.wr_en && !t.rd_en;
    e.addr = t.result; e.wdata = t.sdata; e.dmem_we = store;
    e.rd = t.rd; e.wb_we = !store;
    e.bus = 0; e.err = 0; e.req_cycles = 0; e.wb_data = t.result;
    if (memop && (t.result % 4 != 0)) begin
      e.err = 1; e.wb_data = 32'h0;
    end else if (memop) begin
      e.bus = 1;
      if (t.ack_after >= 0 && t.ack_after < TMO) begin
        e.req_cycles = t.ack_after + 1;
        if (!store) e.wb_data = t.rdata;
      end else begin
        e.req_cycles = TMO; e.err = 1; e.wb_data = 32'h0;
      end
    end
    e.lat = 3 + e.req_cycles;
    return e;
  endfunction

  // Per-cycle compare against the current transaction's expectations.
  bit prev_valid = 0;
  int req_cnt    = 0;
  always @(negedge clk) begin
    if (!cur_active) begin
      req_cnt = 0;
    end else begin
      if (o_dmem_req) begin
        check("req_allowed", 32'(o_dmem_req), 32'(cur_exp.bus));
        check("dmem_addr", o_dmem_addr, cur_exp.addr);
        check("dmem_we", 32'(o_dmem_we), 32'(cur_exp.dmem_we));
        if (cur_exp.dmem_we) check("dmem_wdata", o_dmem_wdata, cur_exp.wdata);
        req_cnt++;
      end
      if (o_wb_valid && !prev_valid) begin
        check("wb_data", o_wb_data, cur_exp.wb_data);
        check("wb_rd", 32'(o_wb_rd), 32'(cur_exp.rd));
        check("wb_we", 32'(o_wb_we), 32'(cur_exp.wb_we));
        check("mem_err", 32'(o_mem_err), 32'(model_err));
        check("req_cycles", 32'(req_cnt), 32'(cur_exp.req_cycles));
        check("flush_with_wb_load", 32'(o_flush), 32'h1);
        req_cnt = 0;
      end else if (o_flush) begin
        check("flush_without_wb_load", 32'(o_flush), 32'h0);
      end
    end
    prev_valid = o_wb_valid;
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_flush"}, 32'(o_flush), 0);
    check({pfx, "_req"}, 32'(o_dmem_req), 0);
    check({pfx, "_dwe"}, 32'(o_dmem_we), 0);
    check({pfx, "_addr"}, o_dmem_addr, 0);
    check({pfx, "_wdata"}, o_dmem_wdata, 0);
    check({pfx, "_wbv"}, 32'(o_wb_valid), 0);
    check({pfx, "_wbd"}, o_wb_data, 0);
    check({pfx, "_wbrd"}, 32'(o_wb_rd), 0);
    check({pfx, "_wbwe"}, 32'(o_wb_we), 0);
    check({pfx, "_err"}, 32'(o_mem_err), 0);
  endtask

  // Present one EX/MEM entry, answer the bus, wait for o_flush (bounded).
  // release_at >= 0 pulses i_wb_flush that many cycles after ready rises.
  task automatic run_txn(input txn_t t, input int release_at, input bit consume,
                         input logic [31:0] lit_data, input int lit_lat);
    exp_t e;
    int   n;
    int   req_seen;
    int   exp_lat;
    bit   flushed;
    e = model(t);
    exp_lat = e.lat;
    if (release_at >= 0 && release_at + 2 > exp_lat) exp_lat = release_at + 2;
    @(negedge clk);
    cur_exp = e; cur_active = 1; model_err = model_err | e.err;
    i_result = t.result; i_store_data = t.sdata; i_mem_read = t.rd_en;
    i_mem_write = t.wr_en; i_rd = t.rd; i_alu_ready = 1;
    n = 0; req_seen = 0; flushed = 0;
    while (!flushed && n < 60) begin
      @(negedge clk);
      n++;
      i_dmem_ack = 0;
      if (release_at >= 0) i_wb_flush = (n == release_at);
      if (n == 2) begin
        i_result = ~t.result; i_store_data = ~t.sdata; i_rd = ~t.rd;
        i_mem_read = ~t.rd_en; i_mem_write = ~t.wr_en;
      end
      if (o_dmem_req) begin
        req_seen++;
        if (req_seen == t.ack_after + 1) begin
          i_dmem_ack = 1; i_dmem_rdata = t.rdata;
        end
      end
      if (o_flush) flushed = 1;
    end
    check("flush_latency_model", 32'(n), 32'(exp_lat));
    check("flush_latency_lit", 32'(n), 32'(lit_lat));
    check("wb_data_lit", o_wb_data, lit_data);
    i_alu_ready = 0; i_dmem_ack = 0; i_wb_flush = 0;
    @(negedge clk);
    check("flush_one_cycle", 32'(o_flush), 0);
    if (consume) begin
      i_wb_flush = 1;
      @(negedge clk);
      i_wb_flush = 0;
    end
  endtask

  initial begin
    int n;
    rst = 0; i_alu_ready = 0; i_result = 0; i_store_data = 0; i_mem_read = 0;
    i_mem_write = 0; i_rd = 0; i_dmem_rdata = 0; i_dmem_ack = 0; i_wb_flush = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1;

    // ALU pass-through, then load/store, load+write flags with ack in the limit cycle.
    run_txn(mk(32'h0000_1234, 32'h0, 0, 0, 5'd5, -1, 32'h0), -1, 1, 32'h0000_1234, 3);
    run_txn(mk(32'h0000_0040, 32'h0, 1, 0, 5'd6, 2, 32'hDEAD_BEEF), -1, 1, 32'hDEAD_BEEF, 6);
    run_txn(mk(32'h0000_0044, 32'hA5A5_A5A5, 0, 1, 5'd7, 0, 32'h0), -1, 1, 32'h0000_0044, 4);
    run_txn(mk(32'h0000_0080, 32'h1111_2222, 1, 1, 5'd8, TMO - 1, 32'h0BAD_F00D), -1, 1,
            32'h0BAD_F00D, 7);
    check("no_err_after_limit_ack", 32'(o_mem_err), 0);

    // rd==0 entry left in MEM/WB, then a timed-out load stalls in PASS until WB consumes.
    run_txn(mk(32'hFFFF_FFFF, 32'h0, 0, 0, 5'd0, -1, 32'h0), -1, 0, 32'hFFFF_FFFF, 3);
    run_txn(mk(32'h0000_0100, 32'h0, 1, 0, 5'd9, -1, 32'h0), 10, 1, 32'h0, 12);
    check("err_after_timeout", 32'(o_mem_err), 1);

    // Reset during ACCESS with ready held high.
    @(negedge clk);
    cur_active = 0;
    i_result = 32'h0000_0200; i_mem_read = 1; i_mem_write = 0; i_rd = 5'd3;
    i_alu_ready = 1;
    n = 0;
    while (!o_dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_req_seen", 32'(o_dmem_req), 1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_err = 0;
    check_zero("mid_rst");
    repeat (6) begin
      @(negedge clk);
      check("no_restart_req", 32'(o_dmem_req), 0);
      check("no_restart_flush", 32'(o_flush), 0);
    end
    i_alu_ready = 0;
    repeat (2) @(negedge clk);

    // Misaligned load: no bus cycle, error, zero data, flush still pulses.
    run_txn(mk(32'h0000_0042, 32'h0, 1, 0, 5'd4, 0, 32'h1234_5678), -1, 1, 32'h0, 3);
    check("err_after_misaligned", 32'(o_mem_err), 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
